sram_req_arbiter: RTL and testbench

Two-requester arbiter that shares one SRAM-like memory port between the instruction-fetch stage and the EXE-stage data access. It accepts req/addr_ok/data_ok handshakes from both requesters, grants one at a time, and drives a single downstream request with at most one transaction outstanding. It sits between the pipeline stages and the memory bridge, and replaces direct data_sram_en/we driving.

---
 rtl/sram_req_arbiter_pkg.sv | 26 ++
 rtl/sram_req_arbiter_pick.sv | 33 +++
 rtl/sram_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the SRAM request arbiter: FSM states, grant ids and
// transfer sizes.
package sram_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_ADDR = 2'd1,
    ARB_ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_GNT_INST = 1'b0,
    ARB_GNT_DATA = 1'b1
  } arb_gnt_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_e;

  function automatic arb_gnt_e other_gnt(input arb_gnt_e g);
    return (g == ARB_GNT_INST) ? ARB_GNT_DATA : ARB_GNT_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_pick.sv
// Combinational winner selector. Fixed data-over-inst priority by default;
// alternating priority when ARB_ROUND_ROBIN_EN is defined.
module sram_arb_pick
  import sram_req_arbiter_pkg::*;
(
  input  logic     inst_req,
  input  logic     data_req,
  input  arb_gnt_e last_grant,
  output logic     any_req,
  output arb_gnt_e winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    any_req = inst_req | data_req;
    winner  = data_req ? ARB_GNT_DATA : ARB_GNT_INST;
    // On a tie, whoever lost last time goes first.
    if (inst_req && data_req) begin
      winner = other_gnt(last_grant);
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data belongs to the older instruction, so it always wins a tie.
  always_comb begin
    any_req = inst_req | data_req;
    winner  = data_req ? ARB_GNT_DATA : ARB_GNT_INST;
  end
`endif

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between IF and EXE with one transaction in flight.
// Optional alternating priority: define ARB_ROUND_ROBIN_EN.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  arb_gnt_e            grant_q, grant_d;
  logic                mem_req_q, mem_req_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                any_req;
  arb_gnt_e            winner;
  arb_gnt_e            last_grant;

`ifdef ARB_ROUND_ROBIN_EN
  arb_gnt_e            last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = ARB_GNT_INST;
`endif

  sram_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  logic                sel_wr;
  logic [1:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [STRB_W-1:0]   sel_wstrb;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    sel_wr    = inst_wr;
    sel_size  = inst_size;
    sel_addr  = inst_addr;
    sel_wstrb = inst_wstrb;
    sel_wdata = inst_wdata;
    if (winner == ARB_GNT_DATA) begin
      sel_wr    = data_wr;
      sel_size  = data_size;
      sel_addr  = data_addr;
      sel_wstrb = data_wstrb;
      sel_wdata = data_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ARB_ST_IDLE: begin
        // Latch the winner's fields so the requester may move on after addr_ok.
        if (any_req) begin
          state_d = ARB_ST_ADDR;
          grant_d = winner;
          wr_d    = sel_wr;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wstrb_d = sel_wstrb;
          wdata_d = sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
        end
      end
      ARB_ST_ADDR: begin
        if (mem_addr_ok) begin
          state_d = ARB_ST_DATA;
        end
      end
      ARB_ST_DATA: begin
        if (mem_data_ok) begin
          state_d = ARB_ST_IDLE;
        end
      end
      default: state_d = ARB_ST_IDLE;
    endcase
    mem_req_d = (state_d == ARB_ST_ADDR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB_ST_IDLE;
      grant_q   <= ARB_GNT_INST;
      mem_req_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= ARB_GNT_INST;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mem_req_q <= mem_req_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

  // Handshakes are combinational so the requester sees them in the same cycle.
  logic in_data;
  assign in_data = (state_q == ARB_ST_DATA);

  assign inst_addr_ok = mem_req_q && (grant_q == ARB_GNT_INST) && mem_addr_ok;
  assign data_addr_ok = mem_req_q && (grant_q == ARB_GNT_DATA) && mem_addr_ok;
  assign inst_data_ok = in_data && (grant_q == ARB_GNT_INST) && mem_data_ok;
  assign data_data_ok = in_data && (grant_q == ARB_GNT_DATA) && mem_data_ok;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed scenarios plus a random
// run compared every cycle against a transaction-level model.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rq_req[2];
  logic        rq_wr[2];
  logic [1:0]  rq_size[2];
  logic [31:0] rq_addr[2];
  logic [3:0]  rq_wstrb[2];
  logic [31:0] rq_wdata[2];
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;

  always #5 clk = ~clk;

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(rq_req[0]), .inst_wr(rq_wr[0]), .inst_size(rq_size[0]),
    .inst_addr(rq_addr[0]), .inst_wstrb(rq_wstrb[0]), .inst_wdata(rq_wdata[0]),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(rq_req[1]), .data_wr(rq_wr[1]), .data_size(rq_size[1]),
    .data_addr(rq_addr[1]), .data_wstrb(rq_wstrb[1]), .data_wdata(rq_wdata[1]),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: one outstanding transfer, owner 0=inst 1=data.
  bit m_busy, m_acc;
  int m_owner, m_last;

  logic        s_aok[2], s_dok[2], s_req;
  logic [31:0] s_addr, s_wdata, s_rd[2];
  logic [3:0]  s_wstrb;
  int          rand_grants;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_owner = 0; m_last = 0;
  endtask

  task automatic model_compare();
    logic e_req;
    e_req = m_busy && !m_acc;
    chk1("mem_req", mem_req, e_req);
    chk1("inst_addr_ok", inst_addr_ok, e_req && m_owner == 0 && mem_addr_ok);
    chk1("data_addr_ok", data_addr_ok, e_req && m_owner == 1 && mem_addr_ok);
    chk1("inst_data_ok", inst_data_ok, m_busy && m_acc && m_owner == 0 && mem_data_ok);
    chk1("data_data_ok", data_data_ok, m_busy && m_acc && m_owner == 1 && mem_data_ok);
    if (e_req) begin
      chk32("mem_addr", mem_addr, rq_addr[m_owner]);
      chk1("mem_wr", mem_wr, rq_wr[m_owner]);
      chk32("mem_size", {30'd0, mem_size}, {30'd0, rq_size[m_owner]});
      chk32("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, rq_wstrb[m_owner]});
      chk32("mem_wdata", mem_wdata, rq_wdata[m_owner]);
    end
    if (m_busy && m_acc && mem_data_ok) begin
      if (m_owner == 0) chk32("inst_rdata", inst_rdata, mem_rdata);
      else              chk32("data_rdata", data_rdata, mem_rdata);
    end
    s_aok[0] = inst_addr_ok; s_aok[1] = data_addr_ok;
    s_dok[0] = inst_data_ok; s_dok[1] = data_data_ok;
    s_rd[0] = inst_rdata; s_rd[1] = data_rdata;
    s_req = mem_req; s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
  endtask

  task automatic model_update();
    if (!resetn) return;
    if (!m_busy) begin
      if (rq_req[0] || rq_req[1]) begin
        if (rq_req[0] && rq_req[1]) m_owner = RR ? 1 - m_last : 1;
        else                        m_owner = rq_req[1] ? 1 : 0;
        m_last = m_owner;
        m_busy = 1;
        m_acc  = 0;
      end
    end else if (!m_acc) begin
      if (mem_addr_ok) m_acc = 1;
    end else if (mem_data_ok) begin
      m_busy = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] wd);
    rq_req[k] = 1'b1; rq_wr[k] = wr; rq_size[k] = 2'd2;
    rq_addr[k] = a; rq_wstrb[k] = st; rq_wdata[k] = wd;
  endtask

  // Zero-wait downstream: completes whichever request the arbiter grants.
  task automatic serve(output int who, output logic [31:0] a);
    bit got;
    who = -1; a = '0; got = 0;
    mem_addr_ok = 1'b1;
    for (int n = 0; n < 8 && who < 0; n++) begin
      step();
      if (s_aok[0])      begin who = 0; a = s_addr; end
      else if (s_aok[1]) begin who = 1; a = s_addr; end
    end
    mem_addr_ok = 1'b0;
    if (who < 0) begin
      checks++; failures++;
      $display("FAIL serve_addr_ok timeout actual=none required=grant");
      return;
    end
    rq_req[who] = 1'b0;
    mem_data_ok = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      step();
      got = s_dok[who];
    end
    mem_data_ok = 1'b0;
    chk1("serve_data_ok", got, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    logic [31:0] a;
    int first_exp[4];
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rq_req[k] = 0; rq_wr[k] = 0; rq_size[k] = 0;
      rq_addr[k] = 0; rq_wstrb[k] = 0; rq_wdata[k] = 0;
    end
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    model_reset();
    rand_grants = 0;
    step(); step();
    chk1("rst_mem_req", s_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_data_ok", s_dok[1] | s_dok[0], 1'b0);
    chk1("rst_addr_ok", s_aok[1] | s_aok[0], 1'b0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    resetn = 1'b1;

    // Single read from EXE.
    set_req(1, 1'b0, 32'h1000, 4'h0, 32'h0);
    step();
    chk1("t1_c1_mem_req", s_req, 1'b0);
    mem_addr_ok = 1'b1;
    step();
    chk1("t1_c2_data_addr_ok", s_aok[1], 1'b1);
    chk1("t1_c2_inst_addr_ok", s_aok[0], 1'b0);
    chk32("t1_c2_mem_addr", s_addr, 32'h1000);
    rq_req[1] = 1'b0; mem_addr_ok = 1'b0;
    step();
    chk1("t1_c3_data_data_ok", s_dok[1], 1'b0);
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    chk1("t1_c4_data_data_ok", s_dok[1], 1'b1);
    chk32("t1_c4_data_rdata", s_rd[1], 32'hDEAD_BEEF);
    chk1("t1_c4_inst_data_ok", s_dok[0], 1'b0);
    mem_data_ok = 1'b0;

    // Simultaneous requests, twice; data was granted last.
    if (RR) begin first_exp[0] = 0; first_exp[1] = 1; first_exp[2] = 0; first_exp[3] = 1; end
    else    begin first_exp[0] = 1; first_exp[1] = 0; first_exp[2] = 1; first_exp[3] = 0; end
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b0, 32'h1c00_0000, 4'h0, 32'h0);
      set_req(1, 1'b0, 32'h2000, 4'h0, 32'h0);
      for (int g = 0; g < 2; g++) begin
        serve(who, a);
        chk32("t2_grant_order", who, first_exp[2*r+g]);
        chk32("t2_grant_addr", a, (who == 0) ? 32'h1c00_0000 : 32'h2000);
      end
    end

    // Write held off by the downstream for three cycles.
    set_req(1, 1'b1, 32'h3000, 4'b0100, 32'h00AB_0000);
    step();
    for (int n = 0; n < 3; n++) begin
      step();
      chk1("t4_mem_req_held", s_req, 1'b1);
      chk32("t4_wdata", s_wdata, 32'h00AB_0000);
      chk32("t4_wstrb", {28'd0, s_wstrb}, 32'h4);
      chk1("t4_no_addr_ok", s_aok[1], 1'b0);
    end
    mem_addr_ok = 1'b1;
    step();
    chk1("t4_addr_ok", s_aok[1], 1'b1);
    rq_req[1] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    step();
    chk1("t4_data_ok", s_dok[1], 1'b1);
    mem_data_ok = 1'b0;

    // Asynchronous reset while waiting for data.
    set_req(1, 1'b0, 32'h4000, 4'h0, 32'h0);
    step();
    mem_addr_ok = 1'b1;
    step();
    rq_req[1] = 1'b0; mem_addr_ok = 1'b0;
    step();
    mem_data_ok = 1'b1;
    #1;
    chk1("t5_pre_data_ok", data_data_ok, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("t5_async_data_ok", data_data_ok, 1'b0);
    chk1("t5_async_mem_req", mem_req, 1'b0);
    chk1("t5_async_inst_ok", inst_data_ok | inst_addr_ok, 1'b0);
    model_reset();
    step();
    resetn = 1'b1;
    step();
    chk1("t5_late_data_ok", s_dok[1], 1'b0);
    mem_data_ok = 1'b0;

    // Spurious mem_data_ok while idle.
    mem_data_ok = 1'b1;
    step();
    chk1("t6_no_data_ok", s_dok[0] | s_dok[1], 1'b0);
    mem_data_ok = 1'b0;
    set_req(0, 1'b0, 32'h5000, 4'h0, 32'h0);
    step();
    chk1("t6_req_latency0", s_req, 1'b0);
    step();
    chk1("t6_req_latency1", s_req, 1'b1);
    serve(who, a);
    chk32("t6_grant", who, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = ($urandom_range(0, 1) != 0);
      mem_rdata   = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (rq_req[k] && s_aok[k]) begin
          rand_grants++;
          rq_req[k] = 1'b0;
        end
        if (!rq_req[k] && $urandom_range(0, 2) == 0) begin
          rq_req[k]   = 1'b1;
          rq_wr[k]    = 1'($urandom_range(0, 1));
          rq_size[k]  = 2'($urandom_range(0, 2));
          rq_addr[k]  = $urandom;
          rq_wstrb[k] = 4'($urandom_range(0, 15));
          rq_wdata[k] = $urandom;
        end
      end
      step();
    end
    chk1("rand_progress", rand_grants > 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
